// File: rtl/gcounter_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray counter family.
// Helpers operate on 64-bit values; callers zero-extend narrower operands.
package gcounter_pkg;

    localparam int GCNT_DEFAULT_WIDTH = 32;

    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits leave the lower result unchanged.
    function automatic logic [63:0] gray2bin(input logic [63:0] g);
        logic [63:0] b;
        b[63] = g[63];
        for (int i = 62; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Purpose: Gray-to-binary decode, bin[i] = XOR of gray[WIDTH-1:i].
// Latency: purely combinational, no registers.
// Backpressure: none; output follows input continuously.
module gray2bin #(
    parameter int WIDTH = gcounter_pkg::GCNT_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = WIDTH'(gcounter_pkg::gray2bin(64'(gray)));
    end

endmodule

// File: rtl/gray_counter_n.sv
// Purpose: loadable up/down Gray-code counter with registered wrap flag.
// Latency: q and wrap update 1 cycle after the sampling edge; bin is combinational from q.
// Backpressure: none; en=0 holds the count.
module gray_counter_n
    import gcounter_pkg::*;
#(
    parameter int WIDTH = GCNT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    // p tracks the parity of q so the step path never needs an XOR tree over q.
    logic             p;
    logic [WIDTH-1:0] scan_mask;
    logic             scan_hit;
    logic [WIDTH-1:0] step_mask;
    logic             step_wraps;

    // Select the bit left of the rightmost 1 in q[WIDTH-2:0]; with no hit, the MSB.
    always_comb begin
        scan_mask = '0;
        scan_hit  = 1'b0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (!scan_hit && q[i]) begin
                scan_mask[i + 1] = 1'b1;
                scan_hit         = 1'b1;
            end
        end
        if (!scan_hit) begin
            scan_mask[WIDTH - 1] = 1'b1;
        end
    end

    // up!=p flips bit 0; otherwise the scan bit. A missed scan is max->0 or 0->max.
    always_comb begin
        step_mask  = (up != p) ? WIDTH'(1) : scan_mask;
        step_wraps = (up == p) && !scan_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            p    <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= WIDTH'(bin2gray(64'(load_val)));
            p    <= load_val[0];
            wrap <= 1'b0;
        end else if (en) begin
            q    <= q ^ step_mask;
            p    <= ~p;
            wrap <= step_wraps;
        end else begin
            wrap <= 1'b0;
        end
    end

    gray2bin #(
        .WIDTH(WIDTH)
    ) u_gray2bin (
        .gray(q),
        .bin (bin)
    );

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: 4-bit instance for sequence/priority/reset, 32-bit for boundary wrap.
module tb_gray_counter_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, up, load;
    logic [3:0]  load_val, q, bin;
    logic        wrap;
    logic        en32, up32, load32;
    logic [31:0] load_val32, q32, bin32;
    logic        wrap32;

    int          nvec  = 0;
    int          nfail = 0;
    logic [3:0]  prev_q;
    logic [31:0] prev_q32;
    logic [3:0]  gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    gray_counter_n #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q), .bin(bin), .wrap(wrap)
    );

    gray_counter_n #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .en(en32), .up(up32), .load(load32),
        .load_val(load_val32), .q(q32), .bin(bin32), .wrap(wrap32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock on the 4-bit instance, then check q, bin, wrap, parity and (for steps) one-bit change.
    task automatic step4(input string tag, input logic [3:0] eq, input logic [3:0] eb,
                         input logic ew, input bit stepped);
        prev_q = q;
        tick();
        chk({tag, " q"}, 64'(q), 64'(eq));
        chk({tag, " bin"}, 64'(bin), 64'(eb));
        chk({tag, " wrap"}, 64'(wrap), 64'(ew));
        chk({tag, " parity"}, 64'(dut.p), 64'(eb[0]));
        if (stepped) chk({tag, " onebit"}, 64'($countones(q ^ prev_q)), 64'd1);
    endtask

    task automatic step32(input string tag, input logic [31:0] eq, input logic [31:0] eb,
                          input logic ew);
        prev_q32 = q32;
        tick();
        chk({tag, " q32"}, 64'(q32), 64'(eq));
        chk({tag, " bin32"}, 64'(bin32), 64'(eb));
        chk({tag, " wrap32"}, 64'(wrap32), 64'(ew));
        chk({tag, " parity32"}, 64'(dut32.p), 64'(eb[0]));
        chk({tag, " onebit32"}, 64'($countones(q32 ^ prev_q32)), 64'd1);
    endtask

    // Reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 chk("rst pulse q", 64'(q), 64'd0);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        en32 = 1'b0; up32 = 1'b1; load32 = 1'b0; load_val32 = '0;
        #1 reset = 1'b1;
        #2;
        chk("reset q", 64'(q), 64'd0);
        chk("reset bin", 64'(bin), 64'd0);
        chk("reset wrap", 64'(wrap), 64'd0);
        chk("reset q32", 64'(q32), 64'd0);
        tick();
        chk("reset held q", 64'(q), 64'd0);
        #2 reset = 1'b0;

        // Full up sequence 0..15, then wrap to 0.
        en = 1'b1; up = 1'b1;
        chk("up0 q", 64'(q), 64'(gseq[0]));
        for (int i = 1; i < 16; i++) begin
            step4($sformatf("up%0d", i), gseq[i], 4'(i), 1'b0, 1'b1);
        end
        step4("upwrap", 4'h0, 4'd0, 1'b1, 1'b1);
        en = 1'b0;
        step4("hold1", 4'h0, 4'd0, 1'b0, 1'b0);
        step4("hold2", 4'h0, 4'd0, 1'b0, 1'b0);

        // Down from 0 wraps to max.
        pulse_reset();
        en = 1'b1; up = 1'b0;
        step4("dnwrap", 4'h8, 4'd15, 1'b1, 1'b1);
        step4("dn14", 4'h9, 4'd14, 1'b0, 1'b1);

        // Load beats enable, then direction changes with no bubble.
        load = 1'b1; load_val = 4'd10; up = 1'b1;
        step4("load10", 4'hF, 4'd10, 1'b0, 1'b0);
        load = 1'b0; up = 1'b0;
        step4("ld dn9", 4'hD, 4'd9, 1'b0, 1'b1);
        up = 1'b1;
        step4("flip up10", 4'hF, 4'd10, 1'b0, 1'b1);
        up = 1'b0;
        step4("flip dn9", 4'hD, 4'd9, 1'b0, 1'b1);
        load = 1'b1; load_val = 4'd15; up = 1'b1;
        step4("load15", 4'h8, 4'd15, 1'b0, 1'b0);
        load = 1'b0;
        step4("ld upwrap", 4'h0, 4'd0, 1'b1, 1'b1);

        // Async reset mid-count at q=6, then resume from 0.
        pulse_reset();
        step4("run1", 4'h1, 4'd1, 1'b0, 1'b1);
        step4("run3", 4'h3, 4'd2, 1'b0, 1'b1);
        step4("run2", 4'h2, 4'd3, 1'b0, 1'b1);
        step4("run6", 4'h6, 4'd4, 1'b0, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk("async rst q", 64'(q), 64'd0);
        chk("async rst bin", 64'(bin), 64'd0);
        #1 reset = 1'b0;
        step4("after rst", 4'h1, 4'd1, 1'b0, 1'b1);

        // Reset held across an edge with load pending must win.
        load = 1'b1; load_val = 4'd5;
        #3 reset = 1'b1;
        tick();
        chk("rst vs load q", 64'(q), 64'd0);
        #2 reset = 1'b0;
        load = 1'b0; en = 1'b0;
        step4("rst vs load hold", 4'h0, 4'd0, 1'b0, 1'b0);

        // 32-bit boundary: load max-1, step up twice, then down across 0.
        load32 = 1'b1; load_val32 = 32'hFFFF_FFFE;
        tick();
        chk("ld32 q32", 64'(q32), 64'h8000_0001);
        chk("ld32 bin32", 64'(bin32), 64'hFFFF_FFFE);
        chk("ld32 wrap32", 64'(wrap32), 64'd0);
        load32 = 1'b0; en32 = 1'b1; up32 = 1'b1;
        step32("up32 max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        step32("up32 wrap", 32'h0000_0000, 32'h0000_0000, 1'b1);
        up32 = 1'b0;
        step32("dn32 wrap", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        en32 = 1'b0;
        tick();
        chk("idle32 wrap32", 64'(wrap32), 64'd0);
        chk("idle32 q32", 64'(q32), 64'h8000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
